// File: rtl/hilo_ctrl_pkg.sv
// Shared constants, state encoding and funct decode for the HI/LO controller.
// Decode of MADD/MADDU/MSUB/MSUBU depends on HILO_MADD_MSUB_EN.
package hilo_ctrl_pkg;

  localparam int FUNCT_W = 6;
  localparam int HILO_W  = 32;
  localparam int MD_W    = 64;

  localparam logic [FUNCT_W-1:0] FUNCT_MULT   = 6'h18;
  localparam logic [FUNCT_W-1:0] FUNCT_MULTU  = 6'h19;
  localparam logic [FUNCT_W-1:0] FUNCT_DIV    = 6'h1A;
  localparam logic [FUNCT_W-1:0] FUNCT_DIVU   = 6'h1B;
  localparam logic [FUNCT_W-1:0] FUNCT2_MADD  = 6'h00;
  localparam logic [FUNCT_W-1:0] FUNCT2_MADDU = 6'h01;
  localparam logic [FUNCT_W-1:0] FUNCT2_MUL   = 6'h02;
  localparam logic [FUNCT_W-1:0] FUNCT2_MSUB  = 6'h04;
  localparam logic [FUNCT_W-1:0] FUNCT2_MSUBU = 6'h05;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_ACCUM = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  typedef enum logic [2:0] {
    CLS_NONE = 3'd0,
    CLS_HILO = 3'd1,
    CLS_MUL  = 3'd2,
    CLS_MADD = 3'd3,
    CLS_MSUB = 3'd4
  } md_cls_e;

  function automatic md_cls_e md_decode(input logic special2, input logic [FUNCT_W-1:0] funct);
    md_cls_e cls;
    cls = CLS_NONE;
    if (!special2) begin
      case (funct)
        FUNCT_MULT, FUNCT_MULTU, FUNCT_DIV, FUNCT_DIVU: cls = CLS_HILO;
        default: cls = CLS_NONE;
      endcase
    end else begin
      case (funct)
        FUNCT2_MUL: cls = CLS_MUL;
`ifdef HILO_MADD_MSUB_EN
        FUNCT2_MADD, FUNCT2_MADDU: cls = CLS_MADD;
        FUNCT2_MSUB, FUNCT2_MSUBU: cls = CLS_MSUB;
`else
        FUNCT2_MADD, FUNCT2_MADDU, FUNCT2_MSUB, FUNCT2_MSUBU: cls = CLS_NONE;
`endif
        default: cls = CLS_NONE;
      endcase
    end
    return cls;
  endfunction

endpackage

// File: rtl/hilo_ctrl_if.sv
// Pipeline-side bundle for hilo_ctrl: instruction, mult/div result, MTHI/MTLO and HI/LO outputs.
interface hilo_ctrl_if;
  import hilo_ctrl_pkg::*;

  logic               op_valid;
  logic               special2;
  logic [FUNCT_W-1:0] funct;
  logic               md_done;
  logic [MD_W-1:0]    md_result;
  logic               mt_hi_we;
  logic               mt_lo_we;
  logic [HILO_W-1:0]  mt_wdata;
  logic               stall_req;
  logic [HILO_W-1:0]  hi;
  logic [HILO_W-1:0]  lo;
  logic [HILO_W-1:0]  mul_result;
  logic               mul_valid;
  logic               timeout_err;

  modport master (
    output op_valid, special2, funct, md_done, md_result, mt_hi_we, mt_lo_we, mt_wdata,
    input  stall_req, hi, lo, mul_result, mul_valid, timeout_err
  );

  modport slave (
    input  op_valid, special2, funct, md_done, md_result, mt_hi_we, mt_lo_we, mt_wdata,
    output stall_req, hi, lo, mul_result, mul_valid, timeout_err
  );

endinterface

// File: rtl/hilo_ctrl_regs.sv
// Architectural HI/LO register pair; a result commit takes priority over MTHI/MTLO.
module hilo_regs
  import hilo_ctrl_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              commit_we,
  input  logic [MD_W-1:0]   commit_data,
  input  logic              mt_en,
  input  logic              mt_hi_we,
  input  logic              mt_lo_we,
  input  logic [HILO_W-1:0] mt_wdata,
  output logic [HILO_W-1:0] hi,
  output logic [HILO_W-1:0] lo
);

  logic [HILO_W-1:0] hi_d, hi_q;
  logic [HILO_W-1:0] lo_d, lo_q;

  always_comb begin
    hi_d = hi_q;
    lo_d = lo_q;
    if (commit_we) begin
      {hi_d, lo_d} = commit_data;
    end else if (mt_en) begin
      if (mt_hi_we) begin
        hi_d = mt_wdata;
      end else begin
        hi_d = hi_q;
      end
      if (mt_lo_we) begin
        lo_d = mt_wdata;
      end else begin
        lo_d = lo_q;
      end
    end else begin
      hi_d = hi_q;
      lo_d = lo_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      hi_q <= {HILO_W{1'b0}};
      lo_q <= {HILO_W{1'b0}};
    end else begin
      hi_q <= hi_d;
      lo_q <= lo_d;
    end
  end

  assign hi = hi_q;
  assign lo = lo_q;

endmodule

// File: rtl/hilo_ctrl.sv
// EX-stage HI/LO controller: stalls on mult/div ops, commits results, MUL writeback.
// Build option HILO_MADD_MSUB_EN adds MADD/MADDU/MSUB/MSUBU accumulation (ACCUM state).
module hilo_ctrl
  import hilo_ctrl_pkg::*;
#(
  parameter int kWaitLimit  = 32,
  parameter int kFunctWidth = FUNCT_W
) (
  input logic        clk,
  input logic        rst,
  input logic        flush,
  hilo_ctrl_if.slave bus
);

  localparam int CNT_W = $clog2(kWaitLimit + 1);
  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(kWaitLimit);

  state_e                 state_d, state_q;
  md_cls_e                cls_d, cls_q;
  md_cls_e                dec_cls_s;
  logic [CNT_W-1:0]       cnt_d, cnt_q;
  logic [HILO_W-1:0]      mul_result_d, mul_result_q;
  logic                   mul_valid_d, mul_valid_q;
  logic                   timeout_d, timeout_q;
  logic                   stall_req_s;
  logic                   commit_we_s;
  logic [MD_W-1:0]        commit_data_s;
  logic [HILO_W-1:0]      hi_s, lo_s;
  logic [kFunctWidth-1:0] funct_s;
`ifdef HILO_MADD_MSUB_EN
  logic [MD_W-1:0]        acc_d, acc_q;
`endif

  assign funct_s   = bus.funct;
  assign dec_cls_s = md_decode(bus.special2, funct_s);

  always_comb begin
    state_d       = state_q;
    cls_d         = cls_q;
    cnt_d         = cnt_q;
    mul_result_d  = mul_result_q;
    mul_valid_d   = 1'b0;
    timeout_d     = 1'b0;
    stall_req_s   = 1'b0;
    commit_we_s   = 1'b0;
    commit_data_s = bus.md_result;
`ifdef HILO_MADD_MSUB_EN
    acc_d         = acc_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (bus.op_valid && (dec_cls_s != CLS_NONE)) begin
          stall_req_s = 1'b1;
          cls_d       = dec_cls_s;
          cnt_d       = {CNT_W{1'b0}};
          state_d     = ST_WAIT;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WAIT: begin
        stall_req_s = 1'b1;
        cnt_d       = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        if (bus.md_done) begin
          case (cls_q)
            CLS_HILO: begin
              commit_we_s = 1'b1;
              state_d     = ST_DONE;
            end
            CLS_MUL: begin
              mul_result_d = bus.md_result[HILO_W-1:0];
              mul_valid_d  = 1'b1;
              state_d      = ST_DONE;
            end
`ifdef HILO_MADD_MSUB_EN
            CLS_MADD, CLS_MSUB: begin
              acc_d   = bus.md_result;
              state_d = ST_ACCUM;
            end
`endif
            default: state_d = ST_IDLE;
          endcase
        end else if (cnt_d == CNT_LIMIT) begin
          // unit never answered: abort without touching HI/LO
          timeout_d = 1'b1;
          state_d   = ST_IDLE;
        end else begin
          state_d = ST_WAIT;
        end
      end
      ST_ACCUM: begin
        stall_req_s = 1'b1;
`ifdef HILO_MADD_MSUB_EN
        commit_we_s = 1'b1;
        if (cls_q == CLS_MSUB) begin
          commit_data_s = {hi_s, lo_s} - acc_q;
        end else begin
          commit_data_s = {hi_s, lo_s} + acc_q;
        end
        state_d = ST_DONE;
`else
        state_d = ST_IDLE;
`endif
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    if (flush) begin
      state_d      = ST_IDLE;
      commit_we_s  = 1'b0;
      mul_valid_d  = 1'b0;
      mul_result_d = mul_result_q;
      timeout_d    = 1'b0;
    end else begin
      state_d = state_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      cls_q        <= CLS_NONE;
      cnt_q        <= {CNT_W{1'b0}};
      mul_result_q <= {HILO_W{1'b0}};
      mul_valid_q  <= 1'b0;
      timeout_q    <= 1'b0;
`ifdef HILO_MADD_MSUB_EN
      acc_q        <= {MD_W{1'b0}};
`endif
    end else begin
      state_q      <= state_d;
      cls_q        <= cls_d;
      cnt_q        <= cnt_d;
      mul_result_q <= mul_result_d;
      mul_valid_q  <= mul_valid_d;
      timeout_q    <= timeout_d;
`ifdef HILO_MADD_MSUB_EN
      acc_q        <= acc_d;
`endif
    end
  end

  hilo_regs u_regs (
    .clk        (clk),
    .rst        (rst),
    .commit_we  (commit_we_s),
    .commit_data(commit_data_s),
    .mt_en      (~flush),
    .mt_hi_we   (bus.mt_hi_we),
    .mt_lo_we   (bus.mt_lo_we),
    .mt_wdata   (bus.mt_wdata),
    .hi         (hi_s),
    .lo         (lo_s)
  );

  assign bus.stall_req   = stall_req_s;
  assign bus.hi          = hi_s;
  assign bus.lo          = lo_s;
  assign bus.mul_result  = mul_result_q;
  assign bus.mul_valid   = mul_valid_q;
  assign bus.timeout_err = timeout_q;

endmodule
